// File: rtl/fft_sr_pair_feeder.sv
// fft_sr_pair_feeder: buffers the first half of each 2*DEPTH-block frame and pairs it with the live second half; optional SOF realignment under FFT_SR_SOF_ALIGN_EN
module fft_sr_pair_feeder #(
  parameter int DATA_W    = 9,
  parameter int UNIT_SIZE = 16,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sync_clr,
  input  logic                     din_valid,
  input  logic                     din_sof,
  input  logic signed [DATA_W-1:0] din_real     [0:UNIT_SIZE-1],
  input  logic signed [DATA_W-1:0] din_imag     [0:UNIT_SIZE-1],
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] out_sr_real  [0:UNIT_SIZE-1],
  output logic signed [DATA_W-1:0] out_sr_imag  [0:UNIT_SIZE-1],
  output logic signed [DATA_W-1:0] out_org_real [0:UNIT_SIZE-1],
  output logic signed [DATA_W-1:0] out_org_imag [0:UNIT_SIZE-1],
  output logic [$clog2(DEPTH)-1:0] dout_idx,
  output logic                     dout_last,
  output logic                     frame_err
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  typedef enum logic {FILL, PAIR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, wr_idx;
  logic wr_en, pair, err;
  logic signed [DATA_W-1:0] buf_re [0:DEPTH-1][0:UNIT_SIZE-1];
  logic signed [DATA_W-1:0] buf_im [0:DEPTH-1][0:UNIT_SIZE-1];
  logic signed [DATA_W-1:0] sr_re_q [0:UNIT_SIZE-1];
  logic signed [DATA_W-1:0] sr_im_q [0:UNIT_SIZE-1];
  logic signed [DATA_W-1:0] org_re_q [0:UNIT_SIZE-1];
  logic signed [DATA_W-1:0] org_im_q [0:UNIT_SIZE-1];
  logic valid_q, last_q, err_q;
  logic [CW-1:0] idx_q;
`ifndef FFT_SR_SOF_ALIGN_EN
  logic unused_sof;
  assign unused_sof = din_sof;
`endif
  // next-state: abort beats input; a misaligned SOF restarts the frame with this block as block 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    pair    = 1'b0;
    err     = 1'b0;
    if (sync_clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (din_valid) begin
`ifdef FFT_SR_SOF_ALIGN_EN
      if (din_sof && !(state_q == FILL && cnt_q == '0)) begin
        err     = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = '0;
        state_d = FILL;
        cnt_d   = CW'(1);
      end else
`endif
      begin
        cnt_d   = cnt_q + CW'(1);
        wr_en   = state_q == FILL;
        pair    = state_q == PAIR;
        state_d = (cnt_q == LAST) ? ((state_q == FILL) ? PAIR : FILL) : state_q;
      end
    end
  end
  // control state and registered pair outputs; outputs hold between pairs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      sr_re_q  <= '{default: '0};
      sr_im_q  <= '{default: '0};
      org_re_q <= '{default: '0};
      org_im_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= pair;
      err_q   <= err;
      if (pair) begin
        idx_q    <= cnt_q;
        last_q   <= cnt_q == LAST;
        sr_re_q  <= buf_re[cnt_q];
        sr_im_q  <= buf_im[cnt_q];
        org_re_q <= din_real;
        org_im_q <= din_imag;
      end
    end
  end
  // first-half block storage, unreset: every slot is written before it is read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_re[wr_idx] <= din_real;
      buf_im[wr_idx] <= din_imag;
    end
  end
  assign valid_out    = valid_q;
  assign frame_err    = err_q;
  assign dout_idx     = idx_q;
  assign dout_last    = last_q;
  assign out_sr_real  = sr_re_q;
  assign out_sr_imag  = sr_im_q;
  assign out_org_real = org_re_q;
  assign out_org_imag = org_im_q;
endmodule
